// File: rtl/exu_mul_sched_pkg.sv
// exu_mul_sched_pkg
//   Shared defaults for the EXU multiply issue scheduler, plus a helper that
//   sizes port-index fields.
//   Ports: none (package).
package exu_mul_sched_pkg;

   localparam int unsigned EXU_N_REQ   = 2;
   localparam int unsigned EXU_MUL_LAT = 3;
   localparam int unsigned EXU_XLEN    = 32;
   localparam int unsigned EXU_TAG_W   = 6;

   // Width of an encoded index into n requesters; never narrower than 1 bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/exu_mul_sched_if.sv
// exu_mul_sched_if
//   Bundles the issue-side request ports, multiplier drive/return signals,
//   writeback handshake, flush and busy of the multiply scheduler.
//   Modports:
//     slave  - the scheduler: takes req_*, flush, mul_result, wb_ready;
//              drives req_ready, mul_*, wb_valid/data/tag/port, busy.
//     master - the surrounding EXU: the reverse directions.
interface exu_mul_sched_if
   import exu_mul_sched_pkg::*;
#(
   parameter int unsigned N_REQ = EXU_N_REQ,
   parameter int unsigned XLEN  = EXU_XLEN,
   parameter int unsigned TAG_W = EXU_TAG_W
);
   localparam int unsigned IDX_W = idx_w(N_REQ);

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ-1:0]       req_signed;
   logic [N_REQ-1:0]       req_low;
   logic [N_REQ*XLEN-1:0]  req_src1;
   logic [N_REQ*XLEN-1:0]  req_src2;
   logic [N_REQ*TAG_W-1:0] req_tag;
   logic                   flush;
   logic                   mul_en;
   logic                   mul_signed;
   logic                   mul_low;
   logic [XLEN-1:0]        mul_src1;
   logic [XLEN-1:0]        mul_src2;
   logic [XLEN-1:0]        mul_result;
   logic                   wb_valid;
   logic                   wb_ready;
   logic [XLEN-1:0]        wb_data;
   logic [TAG_W-1:0]       wb_tag;
   logic [IDX_W-1:0]       wb_port;
   logic                   busy;

   modport slave (
      input  req_valid, req_signed, req_low, req_src1, req_src2, req_tag,
      input  flush, mul_result, wb_ready,
      output req_ready, mul_en, mul_signed, mul_low, mul_src1, mul_src2,
      output wb_valid, wb_data, wb_tag, wb_port, busy
   );

   modport master (
      output req_valid, req_signed, req_low, req_src1, req_src2, req_tag,
      output flush, mul_result, wb_ready,
      input  req_ready, mul_en, mul_signed, mul_low, mul_src1, mul_src2,
      input  wb_valid, wb_data, wb_tag, wb_port, busy
   );

endinterface

// File: rtl/exu_mul_sched_arb.sv
// exu_mul_rr_arb
//   Round-robin pick among N_REQ requesters, searching from ptr upward with
//   wrap. Purely combinational.
//   Ports:
//     req     in  N_REQ  request vector
//     ptr     in  IDX_W  highest-priority index this cycle
//     en      in  1      allow a grant
//     gnt     out N_REQ  one-hot grant (zero when none)
//     gnt_idx out IDX_W  encoded grant index (= ptr when none)
//     gnt_any out 1      a grant was issued
module exu_mul_rr_arb #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             en,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_any
);

   always_comb begin
      int unsigned p;
      logic [IDX_W-1:0] pi;
      gnt     = '0;
      gnt_idx = ptr;
      gnt_any = 1'b0;
      p       = 0;
      pi      = '0;
      if (en) begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            p = 32'(ptr) + i;
            if (p >= N_REQ) p = p - N_REQ;
            pi = IDX_W'(p);
            if (!gnt_any && req[pi]) begin
               gnt[pi] = 1'b1;
               gnt_idx = pi;
               gnt_any = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/exu_mul_sched.sv
// exu_mul_sched
//   Issue scheduler for the shared EXU multiplier. Grants one of N_REQ issue
//   ports round-robin, steers its operands onto mul_*, tracks tag/port of each
//   in-flight op through MUL_LAT stages and presents the result on a
//   valid/ready writeback port. A stalled writeback freezes the whole pipe.
//   Ports:
//     clk  in  clock
//     rst  in  synchronous active-high reset (drops in-flight ops)
//     bus  slave modport of exu_mul_sched_if (requests, multiplier, writeback,
//          flush, busy)
module exu_mul_sched
   import exu_mul_sched_pkg::*;
#(
   parameter int unsigned N_REQ   = EXU_N_REQ,
   parameter int unsigned MUL_LAT = EXU_MUL_LAT,
   parameter int unsigned XLEN    = EXU_XLEN,
   parameter int unsigned TAG_W   = EXU_TAG_W
) (
   input logic            clk,
   input logic            rst,
   exu_mul_sched_if.slave bus
);

   localparam int unsigned IDX_W = idx_w(N_REQ);

   typedef struct packed {
      logic             sgn;
      logic             low;
      logic [XLEN-1:0]  src1;
      logic [XLEN-1:0]  src2;
      logic [TAG_W-1:0] tag;
   } mul_req_t;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [IDX_W-1:0] port;
   } mul_trk_t;

   mul_req_t         req_a [N_REQ];
   mul_trk_t         trk   [1:MUL_LAT];
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] rr_next;
   logic [IDX_W-1:0] sel;
   logic             gnt_any;
   logic             advance;
   logic             grant_en;
   logic             busy_w;

   always_comb begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
         req_a[i].sgn  = bus.req_signed[i];
         req_a[i].low  = bus.req_low[i];
         req_a[i].src1 = bus.req_src1[i*XLEN +: XLEN];
         req_a[i].src2 = bus.req_src2[i*XLEN +: XLEN];
         req_a[i].tag  = bus.req_tag[i*TAG_W +: TAG_W];
      end
   end

   assign advance  = ~trk[MUL_LAT].valid | bus.wb_ready;
   // Grant is also held off during reset so req_ready reads 0 there.
   assign grant_en = advance & ~bus.flush & ~rst;

   exu_mul_rr_arb #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req     (bus.req_valid),
      .ptr     (rr_ptr),
      .en      (grant_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // Without a grant the mux parks on rr_ptr; stage 1 is written invalid then.
   assign sel     = gnt_any ? gnt_idx : rr_ptr;
   assign rr_next = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

   assign bus.req_ready  = gnt;
   assign bus.mul_en     = advance;
   assign bus.mul_signed = req_a[sel].sgn;
   assign bus.mul_low    = req_a[sel].low;
   assign bus.mul_src1   = req_a[sel].src1;
   assign bus.mul_src2   = req_a[sel].src2;

   assign bus.wb_valid = trk[MUL_LAT].valid & ~bus.flush;
   assign bus.wb_data  = bus.mul_result;
   assign bus.wb_tag   = trk[MUL_LAT].tag;
   assign bus.wb_port  = trk[MUL_LAT].port;

   always_comb begin
      busy_w = 1'b0;
      for (int unsigned k = 1; k <= MUL_LAT; k++) busy_w = busy_w | trk[k].valid;
   end
   assign bus.busy = busy_w;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
         for (int unsigned k = 1; k <= MUL_LAT; k++) trk[k] <= '0;
      end else if (bus.flush) begin
         for (int unsigned k = 1; k <= MUL_LAT; k++) trk[k].valid <= 1'b0;
      end else if (advance) begin
         trk[1].valid <= gnt_any;
         trk[1].tag   <= req_a[sel].tag;
         trk[1].port  <= sel;
         for (int unsigned k = 2; k <= MUL_LAT; k++) trk[k] <= trk[k-1];
         if (gnt_any) rr_ptr <= rr_next;
      end
   end

endmodule

// File: tb/tb_exu_mul_sched.sv
module tb_exu_mul_sched;
   import exu_mul_sched_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   exu_mul_sched_if #(.N_REQ(2), .XLEN(32), .TAG_W(6)) ia ();
   exu_mul_sched_if #(.N_REQ(2), .XLEN(32), .TAG_W(6)) ib ();

   exu_mul_sched #(.N_REQ(2), .MUL_LAT(3), .XLEN(32), .TAG_W(6)) dut_a (
      .clk (clk), .rst (rst), .bus (ia.slave));
   exu_mul_sched #(.N_REQ(2), .MUL_LAT(1), .XLEN(32), .TAG_W(6)) dut_b (
      .clk (clk), .rst (rst), .bus (ib.slave));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
      end
   endtask

   function automatic logic [31:0] mulf(input logic s, input logic l,
                                        input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      if (s) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      else   p = {32'd0, a} * {32'd0, b};
      return l ? p[31:0] : p[63:32];
   endfunction

   // Behavioural multipliers standing in for exu_mul_ctl + pipeline regs.
   logic [31:0] mpa1, mpa2, mpa3, mpb;
   always @(posedge clk) begin
      if (ia.mul_en) begin
         mpa1 <= mulf(ia.mul_signed, ia.mul_low, ia.mul_src1, ia.mul_src2);
         mpa2 <= mpa1;
         mpa3 <= mpa2;
      end
      if (ib.mul_en) mpb <= mulf(ib.mul_signed, ib.mul_low, ib.mul_src1, ib.mul_src2);
   end
   assign ia.mul_result = mpa3;
   assign ib.mul_result = mpb;

   // Requester state for dut_a.
   logic        op_s [2];
   logic        op_l [2];
   logic [31:0] op_a [2];
   logic [31:0] op_b [2];
   logic [5:0]  op_t [2];
   int          left [2];
   bit          acc  [2];
   logic [5:0]  tag_ctr = 6'd20;

   task automatic load(input int i);
      op_s[i] = 1'($urandom_range(0, 1));
      op_l[i] = 1'($urandom_range(0, 1));
      op_a[i] = $urandom;
      op_b[i] = $urandom;
      op_t[i] = tag_ctr;
      tag_ctr = tag_ctr + 6'd1;
   endtask

   task automatic drive();
      for (int i = 0; i < 2; i++) begin
         ia.req_valid[i]          = (left[i] > 0);
         ia.req_signed[i]         = op_s[i];
         ia.req_low[i]            = op_l[i];
         ia.req_src1[i*32 +: 32]  = op_a[i];
         ia.req_src2[i*32 +: 32]  = op_b[i];
         ia.req_tag[i*6 +: 6]     = op_t[i];
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (acc[i]) begin
            acc[i] = 1'b0;
            left[i] = left[i] - 1;
            if (left[i] > 0) load(i);
         end
      end
      drive();
   endtask

   // Scoreboard and cycle model for dut_a.
   typedef struct {
      logic [5:0]  tag;
      logic        port;
      logic [31:0] data;
   } sb_t;
   sb_t         q[$];
   logic [3:1]  m_v = '0;
   logic        m_ptr = 1'b0;
   bit          mon_en = 1'b0;
   bit          stall_prev = 1'b0;
   logic [31:0] sv_data;
   logic [5:0]  sv_tag;
   logic        sv_port;

   always @(negedge clk) begin : mon
      logic       adv, wbv, got;
      logic [1:0] eg;
      int         gi, p;
      sb_t        e;
      if (mon_en) begin
         adv = !m_v[3] || ia.wb_ready;
         wbv = m_v[3] && !ia.flush;
         eg  = '0;
         got = 1'b0;
         gi  = 0;
         if (!rst && !ia.flush && adv) begin
            for (int k = 0; k < 2; k++) begin
               p = (int'(m_ptr) + k) % 2;
               if (!got && ia.req_valid[p]) begin
                  got = 1'b1;
                  gi  = p;
                  eg[p] = 1'b1;
               end
            end
         end
         chk("req_ready", 64'(ia.req_ready), 64'(eg));
         chk("mul_en", 64'(ia.mul_en), 64'(adv));
         chk("wb_valid", 64'(ia.wb_valid), 64'(wbv));
         chk("busy", 64'(ia.busy), 64'(|m_v));
         if (stall_prev && !rst) begin
            chk("stall_data", 64'(ia.wb_data), 64'(sv_data));
            chk("stall_tag", 64'(ia.wb_tag), 64'(sv_tag));
            chk("stall_port", 64'(ia.wb_port), 64'(sv_port));
         end
         if (wbv && ia.wb_ready && !rst) begin
            chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("wb_data", 64'(ia.wb_data), 64'(e.data));
               chk("wb_tag", 64'(ia.wb_tag), 64'(e.tag));
               chk("wb_port", 64'(ia.wb_port), 64'(e.port));
            end
         end
         stall_prev = wbv && !ia.wb_ready && !rst;
         sv_data = ia.wb_data;
         sv_tag  = ia.wb_tag;
         sv_port = ia.wb_port;
         if (rst) begin
            m_v = '0;
            m_ptr = 1'b0;
            q.delete();
         end else if (ia.flush) begin
            m_v = '0;
            q.delete();
         end else if (adv) begin
            m_v = {m_v[2:1], got};
            if (got) begin
               m_ptr = (gi == 1) ? 1'b0 : 1'b1;
               e.tag  = op_t[gi];
               e.port = 1'(gi);
               e.data = mulf(op_s[gi], op_l[gi], op_a[gi], op_b[gi]);
               q.push_back(e);
               acc[gi] = 1'b1;
            end
         end
      end
   end

   task automatic drain(input string nm);
      int n;
      n = 0;
      while ((left[0] > 0 || left[1] > 0 || ia.busy !== 1'b0) && n < 200) begin
         step();
         n++;
      end
      chk({nm, "_drain_in_time"}, 64'(n < 200), 64'd1);
      chk({nm, "_sb_empty"}, 64'(q.size()), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         op_s[i] = 1'b0; op_l[i] = 1'b0; op_a[i] = '0; op_b[i] = '0;
         op_t[i] = '0; left[i] = 0; acc[i] = 1'b0;
      end
      ia.flush = 1'b0; ia.wb_ready = 1'b1;
      ib.flush = 1'b0; ib.wb_ready = 1'b1;
      ib.req_valid = '0; ib.req_signed = '0; ib.req_low = '0;
      ib.req_src1 = '0; ib.req_src2 = '0; ib.req_tag = '0;
      drive();

      // Reset state.
      step();
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_wb_valid", 64'(ia.wb_valid), 64'd0);
      chk("rst_req_ready", 64'(ia.req_ready), 64'd0);
      chk("rst_busy", 64'(ia.busy), 64'd0);
      chk("rst_mul_en", 64'(ia.mul_en), 64'd1);

      // 1: single signed-low 7*6 on port 0, latency 3.
      step();
      rst = 1'b0;
      op_s[0] = 1'b1; op_l[0] = 1'b1; op_a[0] = 32'd7; op_b[0] = 32'd6; op_t[0] = 6'd5;
      left[0] = 1;
      drive();
      @(negedge clk);
      chk("t1_ready", 64'(ia.req_ready), 64'b01);
      step(); @(negedge clk); chk("t1_wb_t1", 64'(ia.wb_valid), 64'd0);
      step(); @(negedge clk); chk("t1_wb_t2", 64'(ia.wb_valid), 64'd0);
      step(); @(negedge clk);
      chk("t1_wb_t3", 64'(ia.wb_valid), 64'd1);
      chk("t1_data", 64'(ia.wb_data), 64'd42);
      chk("t1_tag", 64'(ia.wb_tag), 64'd5);
      chk("t1_port", 64'(ia.wb_port), 64'd0);
      drain("t1");

      // 2: both ports streaming right after reset alternate 0,1,0,1.
      rst = 1'b1;
      step();
      rst = 1'b0;
      load(0); load(1);
      left[0] = 6; left[1] = 6;
      drive();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t2_grant", 64'(ia.req_ready), (k % 2 == 1) ? 64'b10 : 64'b01);
         step();
      end
      drain("t2");

      // 3: writeback stall freezes the pipe, then drains without loss.
      load(0); load(1);
      left[0] = 4; left[1] = 4;
      drive();
      repeat (3) step();
      ia.wb_ready = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("t3_mul_en", 64'(ia.mul_en), 64'd0);
         chk("t3_ready", 64'(ia.req_ready), 64'd0);
         chk("t3_wb_valid", 64'(ia.wb_valid), 64'd1);
         step();
      end
      ia.wb_ready = 1'b1;
      drain("t3");

      // 4: flush with three in flight and requests pending.
      load(0); load(1);
      left[0] = 4; left[1] = 4;
      drive();
      repeat (3) step();
      ia.flush = 1'b1;
      @(negedge clk);
      chk("t4_ready", 64'(ia.req_ready), 64'd0);
      chk("t4_wb_valid", 64'(ia.wb_valid), 64'd0);
      chk("t4_busy_before", 64'(ia.busy), 64'd1);
      step();
      ia.flush = 1'b0;
      @(negedge clk);
      chk("t4_busy_after", 64'(ia.busy), 64'd0);
      drain("t4");

      // 5: reset with two ops in flight.
      load(0); load(1);
      left[0] = 4; left[1] = 4;
      drive();
      repeat (2) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_wb_valid", 64'(ia.wb_valid), 64'd0);
      chk("t5_busy", 64'(ia.busy), 64'd0);
      chk("t5_first_grant", 64'(ia.req_ready), 64'b01);
      drain("t5");

      // 6: MUL_LAT=1 build, -1*-1 signed high half, back-to-back.
      ib.req_signed = 2'b01;
      ib.req_low    = 2'b00;
      ib.req_src1   = {32'd0, 32'hFFFF_FFFF};
      ib.req_src2   = {32'd0, 32'hFFFF_FFFF};
      ib.req_valid  = 2'b01;
      for (int k = 0; k < 4; k++) begin
         ib.req_tag = {6'd0, 6'(k + 10)};
         @(negedge clk);
         chk("t6_ready", 64'(ib.req_ready), 64'b01);
         if (k > 0) begin
            chk("t6_wb_valid", 64'(ib.wb_valid), 64'd1);
            chk("t6_wb_tag", 64'(ib.wb_tag), 64'(k + 9));
            chk("t6_wb_data", 64'(ib.wb_data), 64'd0);
            chk("t6_wb_port", 64'(ib.wb_port), 64'd0);
         end
         step();
      end
      ib.req_valid = 2'b00;
      @(negedge clk);
      chk("t6_last_valid", 64'(ib.wb_valid), 64'd1);
      chk("t6_last_tag", 64'(ib.wb_tag), 64'd13);
      chk("t6_last_data", 64'(ib.wb_data), 64'd0);
      step();
      @(negedge clk);
      chk("t6_idle", 64'(ib.wb_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
